// File: rtl/common_reset_sequencer.sv
// Power-up reset release sequencer: waits for a filtered PLL lock after start, then
// releases NUM_STAGES active-low resets in order. Optional lock watchdog: SEQ_WATCHDOG_EN.
module common_reset_sequencer #(
  parameter int MHZ            = 50,
  parameter int NUM_STAGES     = 4,
  parameter int STAGE_DELAY_US = 100,
  parameter int LOCK_FILTER    = 1024,
  parameter int WDT_CYCLES     = 50000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pll_locked,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  done,
  output logic [7:0]            relock_cnt,
  output logic                  lock_timeout
);

  localparam int STAGE_CYCLES = MHZ * STAGE_DELAY_US;
  localparam int DW = $clog2(STAGE_CYCLES + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(STAGE_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(NUM_STAGES - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_LOCK_FILT = 3'd2;
  localparam logic [2:0] ST_RELEASE   = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  logic [2:0]            r_state;
  logic [1:0]            r_sync;
  logic [DW-1:0]         r_dly_cnt;
  logic [FW-1:0]         r_filt_cnt;
  logic [2:0]            r_idx;
  logic [NUM_STAGES-1:0] r_rst_n_out;
  logic                  r_done;
  logic [7:0]            r_relock_cnt;
  logic                  w_lock_s;
  logic [NUM_STAGES-1:0] w_stage_mask;

  assign w_lock_s = r_sync[1];

  // One-hot of the stage being released; avoids indexing with a wider index.
  always_comb begin
    w_stage_mask = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (r_idx == 3'(i)) w_stage_mask[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sync       <= '0;
      r_dly_cnt    <= '0;
      r_filt_cnt   <= '0;
      r_idx        <= '0;
      r_rst_n_out  <= '0;
      r_done       <= 1'b0;
      r_relock_cnt <= '0;
    end else begin
      r_sync <= {r_sync[0], pll_locked};
      case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state    <= ST_LOCK_FILT;
            r_filt_cnt <= '0;
          end
        end
        ST_LOCK_FILT: begin
          if (!w_lock_s) begin
            r_state    <= ST_WAIT_LOCK;
            r_filt_cnt <= '0;
          end else if (r_filt_cnt == FILT_LAST) begin
            r_state    <= ST_RELEASE;
            r_filt_cnt <= '0;
            r_idx      <= '0;
            r_dly_cnt  <= '0;
          end else begin
            r_filt_cnt <= r_filt_cnt + FW'(1);
          end
        end
        ST_RELEASE, ST_DONE: begin
          if (!w_lock_s) begin
            r_state     <= ST_WAIT_LOCK;
            r_rst_n_out <= '0;
            r_done      <= 1'b0;
            r_idx       <= '0;
            r_dly_cnt   <= '0;
            r_filt_cnt  <= '0;
            if (r_relock_cnt != 8'hFF) r_relock_cnt <= r_relock_cnt + 8'd1;
          end else if (r_state == ST_RELEASE) begin
            if (r_dly_cnt == DLY_LAST) begin
              r_rst_n_out <= r_rst_n_out | w_stage_mask;
              r_dly_cnt   <= '0;
              r_idx       <= r_idx + 3'd1;
              if (r_idx == IDX_LAST) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_dly_cnt <= r_dly_cnt + DW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rst_n_out  = r_rst_n_out;
  assign done       = r_done;
  assign relock_cnt = r_relock_cnt;

`ifdef SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
  localparam logic [WW-1:0] WDT_MAX  = WW'(WDT_CYCLES);

  logic [WW-1:0] r_wdt_cnt;
  logic          r_lock_timeout;

  // Keeps counting across filter bounces; only leaving the lock-wait states clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdt_cnt      <= '0;
      r_lock_timeout <= 1'b0;
    end else if (r_state == ST_WAIT_LOCK || r_state == ST_LOCK_FILT) begin
      if (r_wdt_cnt != WDT_MAX) r_wdt_cnt <= r_wdt_cnt + WW'(1);
      if (r_wdt_cnt == WDT_LAST) r_lock_timeout <= 1'b1;
    end else begin
      r_wdt_cnt <= '0;
    end
  end

  assign lock_timeout = r_lock_timeout;
`else
  assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_common_reset_sequencer.sv
// Scoreboard bench for common_reset_sequencer: stimulus pushes expected output events
// (edge number + values); a monitor pops one per observed output change.
module tb_common_reset_sequencer;
  localparam int NS = 3;
  localparam int LF = 3;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          pll_locked;
  logic [NS-1:0] rst_n_out;
  logic          done;
  logic [7:0]    relock_cnt;
  logic          lock_timeout;

  common_reset_sequencer #(
    .MHZ(1), .NUM_STAGES(NS), .STAGE_DELAY_US(4), .LOCK_FILTER(LF), .WDT_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pll_locked(pll_locked),
    .rst_n_out(rst_n_out), .done(done), .relock_cnt(relock_cnt), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            stamp;
    logic [NS-1:0] rst;
    logic          dn;
    logic [7:0]    rel;
  } evt_t;

  evt_t          sb[$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [NS-1:0] m_rst = '0;
  logic          m_done = 1'b0;
  logic [7:0]    m_rel = '0;
  logic          exp_to;
  int            c, d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_evt(input int stamp, input logic [NS-1:0] r, input logic dn,
                            input logic [7:0] rel);
    evt_t e;
    e.stamp = stamp; e.rst = r; e.dn = dn; e.rel = rel;
    sb.push_back(e);
    m_rst = r; m_done = dn; m_rel = rel;
  endtask

  // Latency model: bit k rises at E0 + 1 + LOCK_FILTER + (k+1)*STAGE_CYCLES.
  task automatic expect_seq(input int e0, input logic [7:0] rel);
    logic [NS-1:0] r;
    r = '0;
    for (int k = 0; k < NS; k++) begin
      r[k] = 1'b1;
      expect_evt(e0 + 1 + LF + (k + 1) * SC, r, (k == NS - 1), rel);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() > 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d events still pending after %0d cycles, required 0",
               sb.size(), limit);
      sb.delete();
    end
  endtask

  // Asserts rst_n just after an edge so an asynchronous clear shows before the next edge.
  task automatic apply_reset(input logic pll_v);
    @(posedge clk);
    #1;
    if ({m_rst, m_done, m_rel} != '0) expect_evt(cyc, '0, 1'b0, 8'd0);
    rst_n = 1'b0;
    pll_locked = pll_v;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(output int cs);
    cs = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin : monitor
    logic [NS+8:0] prev, cur;
    evt_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {rst_n_out, done, relock_cnt};
      if (cur !== prev) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output cyc=%0d: got rst_n_out=%b done=%b relock=%0d, required no change",
                   cyc, rst_n_out, done, relock_cnt);
        end else begin
          e = sb.pop_front();
          if (e.stamp != cyc || cur !== {e.rst, e.dn, e.rel}) begin
            n_fail++;
            $display("FAIL output_event: got cyc=%0d rst_n_out=%b done=%b relock=%0d, required cyc=%0d rst_n_out=%b done=%b relock=%0d",
                     cyc, rst_n_out, done, relock_cnt, e.stamp, e.rst, e.dn, e.rel);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : guard
    #1000000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "global timeout");
  end

  initial begin : stim
`ifdef SEQ_WATCHDOG_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    rst_n = 1'b0; start = 1'b0; pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rst_n_out", 32'(rst_n_out), 0);
    check("reset_done", 32'(done), 0);
    check("reset_relock", 32'(relock_cnt), 0);
    check("reset_timeout", 32'(lock_timeout), 0);
    rst_n = 1'b1;
    pll_locked = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_no_start", 32'(rst_n_out), 0);

    // Nominal bring-up
    pulse_start(c);
    expect_seq(c + 1, 8'd0);
    drain(40);
    check("t1_done", 32'(done), 1);
    check("t1_relock", 32'(relock_cnt), 0);

    // Lock loss 5 cycles after done: 2 sync edges then the loss edge
    d = c + 17;
    wait_to(d + 5);
    expect_evt(d + 8, '0, 1'b0, 8'd1);
    expect_seq(d + 12, 8'd1);
    pll_locked = 1'b0;
    wait_to(d + 10);
    pll_locked = 1'b1;
    drain(40);
    check("t3_relock", 32'(relock_cnt), 1);

    // One-cycle lock glitch after 2 filter cycles
    apply_reset(1'b0);
    repeat (3) @(negedge clk);
    pulse_start(c);
    repeat (3) @(negedge clk);
    c = cyc;
    pll_locked = 1'b1;
    wait_to(c + 3);
    pll_locked = 1'b0;
    wait_to(c + 4);
    pll_locked = 1'b1;
    expect_seq(c + 6, 8'd0);
    drain(40);
    check("t2_relock", 32'(relock_cnt), 0);

    // Start held as a level: single sequence, same timing
    apply_reset(1'b1);
    repeat (10) @(negedge clk);
    c = cyc;
    start = 1'b1;
    expect_seq(c + 1, 8'd0);
    drain(40);
    repeat (30) @(negedge clk);
    check("t4_hold_rst", 32'(rst_n_out), 7);
    check("t4_hold_done", 32'(done), 1);
    start = 1'b0;

    // Reset mid-RELEASE, then silence until a new start
    apply_reset(1'b1);
    repeat (10) @(negedge clk);
    pulse_start(c);
    expect_evt(c + 9, 3'b001, 1'b0, 8'd0);
    drain(20);
    apply_reset(1'b1);
    repeat (30) @(negedge clk);
    check("t5_quiet_rst", 32'(rst_n_out), 0);
    check("t5_quiet_done", 32'(done), 0);
    pulse_start(c);
    expect_seq(c + 1, 8'd0);
    drain(40);

    // Watchdog while waiting for lock
    apply_reset(1'b0);
    repeat (3) @(negedge clk);
    pulse_start(c);
    wait_to(c + 20);
    check("t6_wdt_before", 32'(lock_timeout), 0);
    wait_to(c + 21);
    check("t6_wdt_at", 32'(lock_timeout), 32'(exp_to));
    wait_to(c + 25);
    expect_seq(c + 27, 8'd0);
    pll_locked = 1'b1;
    drain(40);
    check("t6_wdt_sticky", 32'(lock_timeout), 32'(exp_to));
    check("t6_done", 32'(done), 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
